generic_sync_fifo: RTL and testbench
====================================

Name: generic_sync_fifo

Overview:
- Vendor-independent, single-clock FIFO with inferred RAM; the parametrised successor to the Altera scfifo wrapper used across the DSI datapath (pixel, command and packet buffers).
- Adds:
  - a full-range fill count
  - runtime-programmable almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags
  - a synchronous clear
  - a selectable normal or show-ahead read mode with defined latencies

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of words; power of two, ≥4.
- USEDW_WIDTH, $clog2(DEPTH)+1, fill-count width; represents 0..DEPTH inclusive.
- SHOWAHEAD, 0, 0 = normal read (q valid 1 cycle after rdreq); 1 = show-ahead (q valid whenever empty=0).

Ports:
- clock, in, 1, FIFO clock.
- aclr, in, 1, asynchronous active-high reset.
- sclr, in, 1, synchronous clear; highest priority over rdreq/wrreq.
- data, in, WIDTH, write data.
- wrreq, in, 1, write request.
- rdreq, in, 1, read request (normal mode) / acknowledge of q (show-ahead mode).
- q, out, WIDTH, read data.
- empty, out, 1, no word available to the reader.
- full, out, 1, usedw == DEPTH.
- usedw, out, USEDW_WIDTH, words held, including any prefetched word.
- almost_full_thr, in, USEDW_WIDTH, almost_full threshold.
- almost_empty_thr, in, USEDW_WIDTH, almost_empty threshold.
- almost_full, out, 1, usedw >= almost_full_thr.
- almost_empty, out, 1, usedw < almost_empty_thr.
- overflow, out, 1, sticky: a write was rejected.
- underflow, out, 1, sticky: a read was rejected.

Behaviour:
- Reset (aclr):
  - pointers, usedw and q = 0; empty = 1; full = 0.
  - overflow and underflow = 0.
  - almost flags are evaluated combinationally from usedw and thresholds.
- sclr: same register effect as aclr, on the clock edge. rdreq/wrreq in that cycle are discarded and not flagged.
- Write acceptance:
  - accepted iff wrreq && !full; data is stored at wr_ptr, which increments modulo DEPTH.
  - wrreq && full: data dropped, overflow set. This holds even with a simultaneous rdreq; a read never frees a slot for the same-cycle write.
- Read acceptance:
  - accepted iff rdreq && !empty.
  - rdreq && empty: ignored, underflow set. This holds even with a simultaneous write.
- usedw / flag timing:
  - usedw is registered: +1 on accepted write only, −1 on accepted read only, unchanged when both are accepted.
  - full and almost flags follow usedw the same cycle (derived from the registered count).
- Normal mode (SHOWAHEAD=0):
  - RAM read is registered; q updates the cycle after an accepted read and holds until the next accepted read.
  - A word written at edge N gives empty=0 after edge N+1.
- Show-ahead mode (SHOWAHEAD=1):
  - A one-word output register prefetches from RAM. q holds the head word whenever empty=0.
  - rdreq pops the head; if a further word exists, the next word appears on q after the following edge (back-to-back reads sustain 1 word/cycle).
  - A write into an empty FIFO at edge N gives empty=0 after edge N+2.
  - usedw counts the prefetched word.
- Pointers wrap at DEPTH with no gap. Full and empty are derived from usedw, not from pointer equality.
- Threshold inputs may change at any time; the flags react combinationally.

Optional Feature:
- Macro: GENERIC_SYNC_FIFO_WATERMARK_EN.
- Defined:
  - adds output max_usedw [USEDW_WIDTH]: the highest usedw seen since aclr/sclr, updated each cycle usedw exceeds it.
  - adds input watermark_clr: synchronously sets max_usedw to the current usedw.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package generic_fifo_pkg holds:
  - FIFO_MODE_NORMAL=0 and FIFO_MODE_SHOWAHEAD=1
  - a clog2-based USEDW width helper
- Sub-module generic_sdp_ram: simple dual-port RAM, WIDTH×DEPTH.
  - One write port, one read port with registered output and read enable.
  - No reset on the array; inferable as M20K/MLAB.

Test Plan:
- DEPTH=16, SHOWAHEAD=0: write 0x01..0x10 on consecutive cycles → full=1 and usedw=16 after the 16th edge. A 17th write of 0xAA → overflow=1, usedw stays 16. Read 16 → q sequence 0x01..0x10, each 1 cycle after rdreq, then empty=1.
- SHOWAHEAD=1: single write 0x5A into empty FIFO at edge N → empty=0 and q=0x5A after edge N+2. rdreq for one cycle → empty=1 next cycle, usedw=0.
- Simultaneous rdreq+wrreq:
  - at usedw=8 → usedw stays 8 and data order preserved.
  - at full → write rejected, overflow=1, usedw=15.
  - at empty → read rejected, underflow=1, usedw=1.
- Thresholds af_thr=12, ae_thr=3: fill 0→16 → almost_empty=1 while usedw<3; almost_full=1 from usedw=12. Change af_thr to 16 at usedw=14 → almost_full drops the same cycle.
- sclr asserted at usedw=9 with rdreq and wrreq high → next cycle usedw=0, empty=1, flags cleared. aclr pulsed mid-burst → all outputs at reset values immediately, without a clock edge.
- Watermark macro defined: fill to 11, drain to 2 → max_usedw=11. watermark_clr → max_usedw=2.

Source files
------------

// File: rtl/generic_fifo_pkg.sv
// Shared definitions for the generic single-clock FIFO: read-mode encodings
// and the fill-count width helper.
package generic_fifo_pkg;

  localparam int FIFO_MODE_NORMAL    = 0;
  localparam int FIFO_MODE_SHOWAHEAD = 1;

  // Fill count must represent 0..depth inclusive, hence one extra bit.
  function automatic int fifo_usedw_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/generic_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered,
// enabled output. The array itself carries no reset so it maps to block RAM.
module generic_sdp_ram
  import generic_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  sclr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is cleared; it is the FIFO's q.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)       rd_data <= '0;
    else if (sclr)  rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/generic_sync_fifo.sv
// Single-clock FIFO with normal or show-ahead read mode, fill count, almost
// flags and sticky error flags. Define GENERIC_SYNC_FIFO_WATERMARK_EN to add max_usedw.
module generic_sync_fifo
  import generic_fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int USEDW_WIDTH = fifo_usedw_width(DEPTH),
  parameter int SHOWAHEAD   = FIFO_MODE_NORMAL
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic                   sclr,
  input  logic [WIDTH-1:0]       data,
  input  logic                   wrreq,
  input  logic                   rdreq,
  output logic [WIDTH-1:0]       q,
  output logic                   empty,
  output logic                   full,
  output logic [USEDW_WIDTH-1:0] usedw,
  input  logic [USEDW_WIDTH-1:0] almost_full_thr,
  input  logic [USEDW_WIDTH-1:0] almost_empty_thr,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
`ifdef GENERIC_SYNC_FIFO_WATERMARK_EN
  ,
  output logic [USEDW_WIDTH-1:0] max_usedw,
  input  logic                   watermark_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [USEDW_WIDTH-1:0] DEPTH_CNT = USEDW_WIDTH'(DEPTH);

  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [USEDW_WIDTH-1:0] usedw_reg, usedw_next;
  logic [USEDW_WIDTH-1:0] ram_words;
  logic                   ram_empty_reg, ram_empty_next;
  logic                   q_valid_reg, q_valid_next;
  logic                   overflow_reg, underflow_reg;
  logic                   empty_int, full_int;
  logic                   wr_acc, rd_acc, ram_rd;

  // ram_empty tracks words old enough to be read from RAM; a word written on
  // one edge only becomes readable on the next, avoiding read-during-write.
  always_comb begin
    full_int       = (usedw_reg == DEPTH_CNT);
    empty_int      = ram_empty_reg;
    ram_rd         = 1'b0;
    ram_words      = usedw_reg;
    usedw_next     = usedw_reg;
    q_valid_next   = q_valid_reg;
    if (SHOWAHEAD == FIFO_MODE_SHOWAHEAD) empty_int = !q_valid_reg;
    wr_acc = wrreq && !full_int && !sclr;
    rd_acc = rdreq && !empty_int && !sclr;
    if (SHOWAHEAD == FIFO_MODE_SHOWAHEAD) begin
      // Prefetch whenever the output register is free or being popped.
      ram_rd    = !ram_empty_reg && (!q_valid_reg || rd_acc) && !sclr;
      ram_words = usedw_reg - USEDW_WIDTH'(q_valid_reg);
      if (ram_rd)      q_valid_next = 1'b1;
      else if (rd_acc) q_valid_next = 1'b0;
    end else begin
      ram_rd = rd_acc;
    end
    case ({wr_acc, rd_acc})
      2'b10:   usedw_next = usedw_reg + USEDW_WIDTH'(1);
      2'b01:   usedw_next = usedw_reg - USEDW_WIDTH'(1);
      default: usedw_next = usedw_reg;
    endcase
    ram_empty_next = ((ram_words - USEDW_WIDTH'(ram_rd)) == '0);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      usedw_reg     <= '0;
      ram_empty_reg <= 1'b1;
      q_valid_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (sclr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      usedw_reg     <= '0;
      ram_empty_reg <= 1'b1;
      q_valid_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (ram_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      usedw_reg     <= usedw_next;
      ram_empty_reg <= ram_empty_next;
      q_valid_reg   <= q_valid_next;
      if (wrreq && full_int)  overflow_reg  <= 1'b1;
      if (rdreq && empty_int) underflow_reg <= 1'b1;
    end
  end

  generic_sdp_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW)
  ) u_ram (
    .clock  (clock),
    .aclr   (aclr),
    .sclr   (sclr),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr_reg),
    .wr_data(data),
    .rd_en  (ram_rd),
    .rd_addr(rd_ptr_reg),
    .rd_data(q)
  );

  assign empty        = empty_int;
  assign full         = full_int;
  assign usedw        = usedw_reg;
  assign almost_full  = (usedw_reg >= almost_full_thr);
  assign almost_empty = (usedw_reg < almost_empty_thr);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

`ifdef GENERIC_SYNC_FIFO_WATERMARK_EN
  logic [USEDW_WIDTH-1:0] max_usedw_reg;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)                          max_usedw_reg <= '0;
    else if (sclr)                     max_usedw_reg <= '0;
    else if (watermark_clr)            max_usedw_reg <= usedw_reg;
    else if (usedw_reg > max_usedw_reg) max_usedw_reg <= usedw_reg;
  end

  assign max_usedw = max_usedw_reg;
`endif

endmodule

// File: tb/tb_generic_sync_fifo.sv
// Bench for generic_sync_fifo: one normal-mode and one show-ahead instance
// driven by shared stimulus, with a queue of expected read data.
module tb_generic_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int UW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aclr, sclr, wrreq, rdreq;
  logic [W-1:0]  data;
  logic [UW-1:0] af_thr, ae_thr;

  logic [W-1:0]  q_n, q_s;
  logic [UW-1:0] usedw_n, usedw_s;
  logic empty_n, full_n, af_n, ae_n, overflow_n, underflow_n;
  logic empty_s, full_s, af_s, ae_s, overflow_s, underflow_s;
`ifdef GENERIC_SYNC_FIFO_WATERMARK_EN
  logic          watermark_clr;
  logic [UW-1:0] max_usedw_n, max_usedw_s;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_w;

  generic_sync_fifo #(.WIDTH(W), .DEPTH(D), .SHOWAHEAD(0)) dut_n (
    .clock(clk), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q_n), .empty(empty_n), .full(full_n), .usedw(usedw_n),
    .almost_full_thr(af_thr), .almost_empty_thr(ae_thr),
    .almost_full(af_n), .almost_empty(ae_n), .overflow(overflow_n), .underflow(underflow_n)
`ifdef GENERIC_SYNC_FIFO_WATERMARK_EN
    , .max_usedw(max_usedw_n), .watermark_clr(watermark_clr)
`endif
  );

  generic_sync_fifo #(.WIDTH(W), .DEPTH(D), .SHOWAHEAD(1)) dut_s (
    .clock(clk), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q_s), .empty(empty_s), .full(full_s), .usedw(usedw_s),
    .almost_full_thr(af_thr), .almost_empty_thr(ae_thr),
    .almost_full(af_s), .almost_empty(ae_s), .overflow(overflow_s), .underflow(underflow_s)
`ifdef GENERIC_SYNC_FIFO_WATERMARK_EN
    , .max_usedw(max_usedw_s), .watermark_clr(watermark_clr)
`endif
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sclr();
    sclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0;
    cycle();
    sclr = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    #1 aclr = 1'b1;
    #1;
    checks++; if (usedw_n !== 5'd0) begin failures++; $display("FAIL reset_usedw_n: got %0d expected 0", usedw_n); end
    checks++; if (empty_n !== 1'b1) begin failures++; $display("FAIL reset_empty_n: got %b expected 1", empty_n); end
    checks++; if (full_n !== 1'b0) begin failures++; $display("FAIL reset_full_n: got %b expected 0", full_n); end
    checks++; if (q_n !== 8'h00) begin failures++; $display("FAIL reset_q_n: got %h expected 00", q_n); end
    checks++; if ({overflow_n, underflow_n} !== 2'b00) begin failures++; $display("FAIL reset_err_n: got %b expected 00", {overflow_n, underflow_n}); end
    checks++; if (empty_s !== 1'b1) begin failures++; $display("FAIL reset_empty_s: got %b expected 1", empty_s); end
    checks++; if (ae_n !== 1'b1) begin failures++; $display("FAIL reset_almost_empty: got %b expected 1", ae_n); end
    cycle();
    aclr = 1'b0;
    cycle();
  endtask

  task automatic test_normal_fill();
    do_sclr();
    for (int i = 1; i <= 16; i++) begin
      data = W'(i); wrreq = 1'b1; sb.push_back(W'(i));
      cycle();
    end
    wrreq = 1'b0;
    checks++; if (full_n !== 1'b1) begin failures++; $display("FAIL fill_full: got %b expected 1", full_n); end
    checks++; if (usedw_n !== 5'd16) begin failures++; $display("FAIL fill_usedw: got %0d expected 16", usedw_n); end
    checks++; if (q_n !== 8'h00) begin failures++; $display("FAIL fill_q_idle: got %h expected 00", q_n); end
    data = 8'hAA; wrreq = 1'b1;
    cycle();
    wrreq = 1'b0;
    checks++; if (overflow_n !== 1'b1) begin failures++; $display("FAIL fill_overflow: got %b expected 1", overflow_n); end
    checks++; if (usedw_n !== 5'd16) begin failures++; $display("FAIL fill_usedw_after_ovf: got %0d expected 16", usedw_n); end
    for (int i = 0; i < 16; i++) begin
      rdreq = 1'b1;
      cycle();
      exp_w = sb.pop_front();
      $display("txn normal_read %0d q=%h exp=%h", i, q_n, exp_w);
      checks++; if (q_n !== exp_w) begin failures++; $display("FAIL normal_read_q: got %h expected %h", q_n, exp_w); end
    end
    rdreq = 1'b0;
    checks++; if (empty_n !== 1'b1) begin failures++; $display("FAIL drain_empty: got %b expected 1", empty_n); end
    checks++; if (usedw_n !== 5'd0) begin failures++; $display("FAIL drain_usedw: got %0d expected 0", usedw_n); end
    checks++; if (underflow_n !== 1'b0) begin failures++; $display("FAIL drain_underflow: got %b expected 0", underflow_n); end
    cycle();
    checks++; if (q_n !== 8'h10) begin failures++; $display("FAIL q_hold: got %h expected 10", q_n); end
  endtask

  task automatic test_showahead_single();
    do_sclr();
    data = 8'h5A; wrreq = 1'b1;
    cycle();
    wrreq = 1'b0;
    checks++; if (empty_s !== 1'b1) begin failures++; $display("FAIL sa_empty_n0: got %b expected 1", empty_s); end
    cycle();
    checks++; if (empty_s !== 1'b1) begin failures++; $display("FAIL sa_empty_n1: got %b expected 1", empty_s); end
    cycle();
    checks++; if (empty_s !== 1'b0) begin failures++; $display("FAIL sa_empty_n2: got %b expected 0", empty_s); end
    checks++; if (q_s !== 8'h5A) begin failures++; $display("FAIL sa_q_n2: got %h expected 5a", q_s); end
    checks++; if (usedw_s !== 5'd1) begin failures++; $display("FAIL sa_usedw: got %0d expected 1", usedw_s); end
    rdreq = 1'b1;
    cycle();
    rdreq = 1'b0;
    checks++; if (empty_s !== 1'b1) begin failures++; $display("FAIL sa_pop_empty: got %b expected 1", empty_s); end
    checks++; if (usedw_s !== 5'd0) begin failures++; $display("FAIL sa_pop_usedw: got %0d expected 0", usedw_s); end
    checks++; if (underflow_s !== 1'b0) begin failures++; $display("FAIL sa_pop_underflow: got %b expected 0", underflow_s); end
  endtask

  task automatic test_showahead_stream();
    do_sclr();
    for (int i = 0; i < 8; i++) begin
      data = W'(8'h30 + i); wrreq = 1'b1; sb.push_back(data);
      cycle();
    end
    wrreq = 1'b0;
    cycle(); cycle();
    for (int i = 0; i < 8; i++) begin
      exp_w = sb.pop_front();
      $display("txn showahead_read %0d q=%h exp=%h empty=%b", i, q_s, exp_w, empty_s);
      checks++; if (empty_s !== 1'b0) begin failures++; $display("FAIL sa_stream_empty: got %b expected 0", empty_s); end
      checks++; if (q_s !== exp_w) begin failures++; $display("FAIL sa_stream_q: got %h expected %h", q_s, exp_w); end
      rdreq = 1'b1;
      cycle();
    end
    rdreq = 1'b0;
    checks++; if (empty_s !== 1'b1) begin failures++; $display("FAIL sa_stream_end_empty: got %b expected 1", empty_s); end
    checks++; if (usedw_s !== 5'd0) begin failures++; $display("FAIL sa_stream_end_usedw: got %0d expected 0", usedw_s); end
  endtask

  task automatic test_back_to_back();
    // Simultaneous read and write at half fill
    do_sclr();
    for (int i = 0; i < 8; i++) begin
      data = W'(8'h40 + i); wrreq = 1'b1; sb.push_back(data);
      cycle();
    end
    wrreq = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) begin
      data = W'(8'h50 + i); wrreq = 1'b1; rdreq = 1'b1; sb.push_back(data);
      cycle();
      exp_w = sb.pop_front();
      checks++; if (q_n !== exp_w) begin failures++; $display("FAIL rw_mid_q: got %h expected %h", q_n, exp_w); end
      checks++; if (usedw_n !== 5'd8) begin failures++; $display("FAIL rw_mid_usedw: got %0d expected 8", usedw_n); end
    end
    wrreq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rdreq = 1'b1;
      cycle();
      exp_w = sb.pop_front();
      $display("txn rw_drain %0d q=%h exp=%h", i, q_n, exp_w);
      checks++; if (q_n !== exp_w) begin failures++; $display("FAIL rw_drain_q: got %h expected %h", q_n, exp_w); end
    end
    rdreq = 1'b0;
    // Simultaneous read and write at full
    do_sclr();
    for (int i = 0; i < 16; i++) begin
      data = W'(8'h70 + i); wrreq = 1'b1; sb.push_back(data);
      cycle();
    end
    wrreq = 1'b0;
    cycle();
    data = 8'hBB; wrreq = 1'b1; rdreq = 1'b1;
    cycle();
    wrreq = 1'b0; rdreq = 1'b0;
    exp_w = sb.pop_front();
    checks++; if (q_n !== exp_w) begin failures++; $display("FAIL rw_full_q: got %h expected %h", q_n, exp_w); end
    checks++; if (overflow_n !== 1'b1) begin failures++; $display("FAIL rw_full_overflow: got %b expected 1", overflow_n); end
    checks++; if (usedw_n !== 5'd15) begin failures++; $display("FAIL rw_full_usedw: got %0d expected 15", usedw_n); end
    // Simultaneous read and write at empty
    do_sclr();
    cycle();
    data = 8'hCC; wrreq = 1'b1; rdreq = 1'b1; sb.push_back(data);
    cycle();
    wrreq = 1'b0; rdreq = 1'b0;
    checks++; if (underflow_n !== 1'b1) begin failures++; $display("FAIL rw_empty_underflow: got %b expected 1", underflow_n); end
    checks++; if (usedw_n !== 5'd1) begin failures++; $display("FAIL rw_empty_usedw: got %0d expected 1", usedw_n); end
    checks++; if (overflow_n !== 1'b0) begin failures++; $display("FAIL rw_empty_overflow: got %b expected 0", overflow_n); end
    cycle();
    checks++; if (empty_n !== 1'b0) begin failures++; $display("FAIL rw_empty_ready: got %b expected 0", empty_n); end
    rdreq = 1'b1;
    cycle();
    rdreq = 1'b0;
    exp_w = sb.pop_front();
    checks++; if (q_n !== exp_w) begin failures++; $display("FAIL rw_empty_q: got %h expected %h", q_n, exp_w); end
  endtask

  task automatic test_thresholds();
    do_sclr();
    af_thr = 5'd12; ae_thr = 5'd3;
    for (int k = 0; k <= 14; k++) begin
      checks++; if (usedw_n !== UW'(k)) begin failures++; $display("FAIL thr_usedw: got %0d expected %0d", usedw_n, k); end
      checks++; if (ae_n !== (k < 3)) begin failures++; $display("FAIL thr_almost_empty: got %b expected %b at usedw %0d", ae_n, (k < 3), k); end
      checks++; if (af_n !== (k >= 12)) begin failures++; $display("FAIL thr_almost_full: got %b expected %b at usedw %0d", af_n, (k >= 12), k); end
      if (k < 14) begin
        data = W'(k); wrreq = 1'b1;
        cycle();
        wrreq = 1'b0;
      end
    end
    af_thr = 5'd16;
    #1;
    checks++; if (af_n !== 1'b0) begin failures++; $display("FAIL thr_change_af: got %b expected 0", af_n); end
    wrreq = 1'b1;
    cycle(); cycle();
    wrreq = 1'b0;
    checks++; if (af_n !== 1'b1) begin failures++; $display("FAIL thr_af_at_16: got %b expected 1", af_n); end
    af_thr = 5'd12;
  endtask

  task automatic test_sclr();
    do_sclr();
    rdreq = 1'b1;
    cycle();
    rdreq = 1'b0;
    checks++; if (underflow_n !== 1'b1) begin failures++; $display("FAIL sclr_pre_underflow: got %b expected 1", underflow_n); end
    for (int i = 0; i < 9; i++) begin
      data = W'(i + 1); wrreq = 1'b1;
      cycle();
    end
    sclr = 1'b1; rdreq = 1'b1; wrreq = 1'b1; data = 8'hEE;
    cycle();
    sclr = 1'b0; rdreq = 1'b0; wrreq = 1'b0;
    checks++; if (usedw_n !== 5'd0) begin failures++; $display("FAIL sclr_usedw: got %0d expected 0", usedw_n); end
    checks++; if (empty_n !== 1'b1) begin failures++; $display("FAIL sclr_empty: got %b expected 1", empty_n); end
    checks++; if ({overflow_n, underflow_n, full_n} !== 3'b000) begin failures++; $display("FAIL sclr_flags: got %b expected 000", {overflow_n, underflow_n, full_n}); end
    cycle();
    checks++; if (usedw_n !== 5'd0) begin failures++; $display("FAIL sclr_write_discarded: got %0d expected 0", usedw_n); end
  endtask

  task automatic test_aclr();
    do_sclr();
    for (int i = 0; i < 8; i++) begin
      data = W'(8'h60 + i); wrreq = 1'b1; rdreq = (i == 5);
      cycle();
    end
    rdreq = 1'b0;
    checks++; if (q_n !== 8'h60) begin failures++; $display("FAIL aclr_pre_q: got %h expected 60", q_n); end
    #3 aclr = 1'b1;
    #1;
    checks++; if (q_n !== 8'h00) begin failures++; $display("FAIL aclr_q_n: got %h expected 00", q_n); end
    checks++; if (usedw_n !== 5'd0) begin failures++; $display("FAIL aclr_usedw_n: got %0d expected 0", usedw_n); end
    checks++; if ({empty_n, full_n} !== 2'b10) begin failures++; $display("FAIL aclr_flags_n: got %b expected 10", {empty_n, full_n}); end
    checks++; if (q_s !== 8'h00) begin failures++; $display("FAIL aclr_q_s: got %h expected 00", q_s); end
    checks++; if (empty_s !== 1'b1) begin failures++; $display("FAIL aclr_empty_s: got %b expected 1", empty_s); end
    aclr = 1'b0; wrreq = 1'b0;
    cycle();
  endtask

`ifdef GENERIC_SYNC_FIFO_WATERMARK_EN
  task automatic test_watermark();
    do_sclr();
    for (int i = 0; i < 11; i++) begin
      data = W'(i); wrreq = 1'b1;
      cycle();
    end
    wrreq = 1'b0;
    cycle(); cycle();
    for (int i = 0; i < 9; i++) begin
      rdreq = 1'b1;
      cycle();
    end
    rdreq = 1'b0;
    cycle();
    checks++; if (usedw_n !== 5'd2) begin failures++; $display("FAIL wm_usedw: got %0d expected 2", usedw_n); end
    checks++; if (max_usedw_n !== 5'd11) begin failures++; $display("FAIL wm_max_n: got %0d expected 11", max_usedw_n); end
    checks++; if (max_usedw_s !== 5'd11) begin failures++; $display("FAIL wm_max_s: got %0d expected 11", max_usedw_s); end
    watermark_clr = 1'b1;
    cycle();
    watermark_clr = 1'b0;
    checks++; if (max_usedw_n !== 5'd2) begin failures++; $display("FAIL wm_clr_n: got %0d expected 2", max_usedw_n); end
    checks++; if (max_usedw_s !== 5'd2) begin failures++; $display("FAIL wm_clr_s: got %0d expected 2", max_usedw_s); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    aclr = 1'b0; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0;
    af_thr = 5'd12; ae_thr = 5'd3;
`ifdef GENERIC_SYNC_FIFO_WATERMARK_EN
    watermark_clr = 1'b0;
`endif
    test_reset();
    test_normal_fill();
    test_showahead_single();
    test_showahead_stream();
    test_back_to_back();
    test_thresholds();
    test_sclr();
    test_aclr();
`ifdef GENERIC_SYNC_FIFO_WATERMARK_EN
    test_watermark();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
